axi4lite_regfile: RTL and testbench

AXI4LITE_REGFILE -- requirements
Module: axi4lite_regfile

---
 rtl/axi4lite_regfile_if.sv | 33 +++
 rtl/axi4lite_regfile.sv | 173 +++++++++++++++++
 tb/tb_axi4lite_regfile.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file: five channels, master/slave views.
interface axi4lite_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite register file: NUM_REGS words, per-register read-only option,
// byte strobes, SLVERR on out-of-range or read-only writes.

// One writable register with byte-granular update.
module axi4lite_regfile_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                we,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);
  // Only strobed bytes take the new data.
  always_ff @(posedge aclk) begin
    if (areset) q <= RESET_VAL;
    else if (we) begin
      for (int k = 0; k < DATA_W/8; k++)
        if (strb[k]) q[k*8 +: 8] <= wdata[k*8 +: 8];
    end
  end
endmodule

module axi4lite_regfile #(
  parameter int                  DATA_W    = 32,
  parameter int                  ADDR_W    = 32,
  parameter int                  NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  axi4lite_regfile_if.slave          s,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] ro_d
);
  localparam int         IDX_LSB = $clog2(DATA_W/8);
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
  } wr_req_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // ---------------- write channel ----------------
  logic        aw_held, w_held;
  wr_req_t     wr_q, wr_cur;
  logic        aw_fire, w_fire, commit;
  logic [ADDR_W-1:0] wr_idx;
  logic        wr_oor, wr_ro, wr_err;
  logic        b_valid;
  logic [1:0]  b_resp;

  // Ready is a function of registered state only; reset forces it low.
  assign s.aw_ready = !areset && !aw_held && !b_valid;
  assign s.w_ready  = !areset && !w_held  && !b_valid;
  assign s.b_valid  = b_valid;
  assign s.b_resp   = b_resp;

  assign aw_fire = s.aw_valid && s.aw_ready;
  assign w_fire  = s.w_valid  && s.w_ready;
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire);

  // The commit uses whichever half was captured earlier, else the live bus.
  assign wr_cur.addr = aw_held ? wr_q.addr : s.aw_addr;
  assign wr_cur.data = w_held  ? wr_q.data : s.w_data;
  assign wr_cur.strb = w_held  ? wr_q.strb : s.w_strb;

  assign wr_idx = wr_cur.addr >> IDX_LSB;
  assign wr_oor = wr_idx >= ADDR_W'(NUM_REGS);
  assign wr_err = wr_oor || wr_ro;

  // Read-only lookup for the write target (0 when out of range).
  always_comb begin
    wr_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (wr_idx == ADDR_W'(i)) wr_ro = RO_MASK[i];
  end

  // Capture flags, held address/data and the write response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      b_valid <= 1'b0;
      b_resp  <= OKAY;
      wr_q    <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_err ? SLVERR : OKAY;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          wr_q.addr <= s.aw_addr;
        end
        if (w_fire) begin
          w_held    <= 1'b1;
          wr_q.data <= s.w_data;
          wr_q.strb <= s.w_strb;
        end
      end
      if (b_valid && s.b_ready) b_valid <= 1'b0;
    end
  end

  // ---------------- register array ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs[i] = ro_d[i*DATA_W +: DATA_W];
    end else begin : g_rw
      // Hardware value is not consumed for writable registers.
      logic unused_ro;
      assign unused_ro = ^ro_d[i*DATA_W +: DATA_W];
      axi4lite_regfile_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_reg (
        .aclk   (aclk),
        .areset (areset),
        .we     (commit && !wr_err && (wr_idx == ADDR_W'(i))),
        .strb   (wr_cur.strb),
        .wdata  (wr_cur.data),
        .q      (regs[i])
      );
    end
  end

  assign reg_q = regs;

  // ---------------- read channel ----------------
  logic              r_valid;
  logic [DATA_W-1:0] r_data, rd_mux;
  logic [1:0]        r_resp;
  logic [ADDR_W-1:0] rd_idx;
  logic              ar_fire, rd_oor;

  assign s.ar_ready = !areset && !r_valid;
  assign s.r_valid  = r_valid;
  assign s.r_data   = r_data;
  assign s.r_resp   = r_resp;

  assign ar_fire = s.ar_valid && s.ar_ready;
  assign rd_idx  = s.ar_addr >> IDX_LSB;
  assign rd_oor  = rd_idx >= ADDR_W'(NUM_REGS);

  // Register select; regs still holds pre-commit values on a colliding edge.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == ADDR_W'(i)) rd_mux = regs[i];
  end

  // Read response register, held until the R handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= OKAY;
    end else if (ar_fire) begin
      r_valid <= 1'b1;
      r_data  <= rd_oor ? '0 : rd_mux;
      r_resp  <= rd_oor ? SLVERR : OKAY;
    end else if (r_valid && s.r_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed bench for axi4lite_regfile: vector table plus multi-cycle sequences.
module tb_axi4lite_regfile;
  localparam int NR = 8;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [NR*32-1:0] reg_q;
  logic [NR*32-1:0] ro_d;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [NR];

  always #5 aclk = ~aclk;

  axi4lite_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4lite_regfile #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(NR),
    .RO_MASK(8'b0000_1000), .RESET_VAL(32'h0)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s      (bus),
    .reg_q  (reg_q),
    .ro_d   (ro_d)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_exp();
    logic [255:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_go, w_go, got = 0;
    int n = 0;
    bus.aw_valid = 1; bus.aw_addr = addr;
    bus.w_valid = 1; bus.w_data = data; bus.w_strb = strb;
    bus.b_ready = 1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk); aw_go = bus.aw_ready; w_go = bus.w_ready;
      @(posedge aclk); #1;
      if (aw_go && !aw_done) begin aw_done = 1; bus.aw_valid = 0; end
      if (w_go && !w_done) begin w_done = 1; bus.w_valid = 0; end
      n++;
    end
    bus.aw_valid = 0; bus.w_valid = 0;
    resp = 2'b11;
    n = 0;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (bus.b_valid) begin got = 1; resp = bus.b_resp; end
      n++;
    end
    check("b_handshake", 256'(got), 256'(1));
    @(posedge aclk); #1;
    bus.b_ready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0, go, got = 0;
    int n = 0;
    bus.ar_valid = 1; bus.ar_addr = addr; bus.r_ready = 1;
    while (!done && n < 20) begin
      @(negedge aclk); go = bus.ar_ready;
      @(posedge aclk); #1;
      if (go) begin done = 1; bus.ar_valid = 0; end
      n++;
    end
    bus.ar_valid = 0;
    data = 32'hx; resp = 2'b11;
    n = 0;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (bus.r_valid) begin got = 1; data = bus.r_data; resp = bus.r_resp; end
      n++;
    end
    check("r_handshake", 256'(got), 256'(1));
    @(posedge aclk); #1;
    bus.r_ready = 0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          idx;    // -1 when out of range
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [1:0] br, rr;
    logic [31:0] rd;

    vecs[0] = '{32'h04,   32'h12345678, 4'hF,  1, 2'b00, 32'h12345678, 2'b00};
    vecs[1] = '{32'h00,   32'hA5A5A5A5, 4'hF,  0, 2'b00, 32'hA5A5A5A5, 2'b00};
    vecs[2] = '{32'h01,   32'h11223344, 4'h3,  0, 2'b00, 32'hA5A53344, 2'b00};
    vecs[3] = '{32'h14,   32'hFFFFFFFF, 4'h0,  5, 2'b00, 32'h00000000, 2'b00};
    vecs[4] = '{32'h20,   32'hDEADBEEF, 4'hF, -1, 2'b10, 32'h00000000, 2'b10};
    vecs[5] = '{32'h0C,   32'h01010101, 4'hF,  3, 2'b10, 32'hCAFEF00D, 2'b00};
    vecs[6] = '{32'h1C,   32'h87654321, 4'hC,  7, 2'b00, 32'h87650000, 2'b00};
    vecs[7] = '{32'h1000, 32'h0BADF00D, 4'hF, -1, 2'b10, 32'h00000000, 2'b10};

    ro_d = '0;
    ro_d[3*32 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    exp_regs[3] = 32'hCAFEF00D;
    bus.aw_valid = 0; bus.aw_addr = '0; bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0;
    bus.b_ready = 0; bus.ar_valid = 0; bus.ar_addr = '0; bus.r_ready = 0;

    // Reset state.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_aw_ready", 256'(bus.aw_ready), 256'(0));
    check("rst_w_ready",  256'(bus.w_ready),  256'(0));
    check("rst_ar_ready", 256'(bus.ar_ready), 256'(0));
    check("rst_b_valid",  256'(bus.b_valid),  256'(0));
    check("rst_r_valid",  256'(bus.r_valid),  256'(0));
    check("rst_reg_q",    reg_q, pack_exp());
    @(posedge aclk); #1;
    areset = 0;
    @(negedge aclk);
    check("post_rst_readies", 256'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 256'(3'b111));

    // W first to reg 2, AW three cycles later.
    bus.w_valid = 1; bus.w_data = 32'hAABBCCDD; bus.w_strb = 4'h5;
    @(posedge aclk); #1;
    bus.w_valid = 0;
    repeat (3) begin
      @(negedge aclk);
      check("wfirst_w_ready_low", 256'(bus.w_ready), 256'(0));
      check("wfirst_b_valid_low", 256'(bus.b_valid), 256'(0));
    end
    bus.aw_valid = 1; bus.aw_addr = 32'h08; bus.b_ready = 1;
    @(posedge aclk); #1;
    bus.aw_valid = 0;
    @(negedge aclk);
    exp_regs[2] = 32'h00BB00DD;
    check("wfirst_b_valid", 256'(bus.b_valid), 256'(1));
    check("wfirst_b_resp",  256'(bus.b_resp),  256'(0));
    check("wfirst_reg_q",   reg_q, pack_exp());
    @(posedge aclk); #1;
    bus.b_ready = 0;

    // Table: write, read back, check whole register image.
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, br);
      check($sformatf("v%0d_bresp", i), 256'(br), 256'(vecs[i].bresp));
      axi_read(vecs[i].addr, rd, rr);
      check($sformatf("v%0d_rdata", i), 256'(rd), 256'(vecs[i].rdata));
      check($sformatf("v%0d_rresp", i), 256'(rr), 256'(vecs[i].rresp));
      if (vecs[i].idx >= 0 && vecs[i].idx != 3) exp_regs[vecs[i].idx] = vecs[i].rdata;
      check($sformatf("v%0d_reg_q", i), reg_q, pack_exp());
    end

    // B stall with a same-edge read of the target register.
    bus.aw_valid = 1; bus.aw_addr = 32'h04; bus.w_valid = 1; bus.w_data = 32'h0F0F0F0F;
    bus.w_strb = 4'hF; bus.ar_valid = 1; bus.ar_addr = 32'h04;
    @(negedge aclk);
    check("stall_readies", 256'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 256'(3'b111));
    @(posedge aclk); #1;
    bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
    exp_regs[1] = 32'h0F0F0F0F;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("stall_b_valid",  256'(bus.b_valid), 256'(1));
      check("stall_b_resp",   256'(bus.b_resp),  256'(0));
      check("stall_aw_w_rdy", 256'({bus.aw_ready, bus.w_ready}), 256'(0));
      check("stall_r_data",   256'(bus.r_data),  256'(32'h12345678));
      check("stall_r_valid",  256'(bus.r_valid), 256'(1));
    end
    check("stall_reg_q", reg_q, pack_exp());
    bus.b_ready = 1; bus.r_ready = 1;
    @(posedge aclk); #1;
    bus.b_ready = 0; bus.r_ready = 0;
    @(negedge aclk);
    check("unstall_valids",  256'({bus.b_valid, bus.r_valid}), 256'(0));
    check("unstall_readies", 256'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 256'(3'b111));

    // Reset after AW captured, before W.
    @(posedge aclk); #1;
    bus.aw_valid = 1; bus.aw_addr = 32'h18;
    @(posedge aclk); #1;
    bus.aw_valid = 0;
    @(negedge aclk);
    check("held_aw_ready", 256'({bus.aw_ready, bus.w_ready}), 256'(2'b01));
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    for (int i = 0; i < NR; i++) if (i != 3) exp_regs[i] = 32'h0;
    @(negedge aclk);
    check("midrst_readies", 256'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 256'(3'b111));
    check("midrst_valids",  256'({bus.b_valid, bus.r_valid}), 256'(0));
    check("midrst_r_data",  256'(bus.r_data), 256'(0));
    check("midrst_reg_q",   reg_q, pack_exp());
    bus.w_valid = 1; bus.w_data = 32'h55555555; bus.w_strb = 4'hF;
    @(posedge aclk); #1;
    bus.w_valid = 0;
    repeat (2) @(negedge aclk);
    check("midrst_no_commit", 256'({bus.b_valid, bus.w_ready, bus.aw_ready}), 256'(3'b001));
    check("midrst_reg_q2",    reg_q, pack_exp());
    bus.aw_valid = 1; bus.aw_addr = 32'h18; bus.b_ready = 1;
    @(posedge aclk); #1;
    bus.aw_valid = 0;
    @(negedge aclk);
    exp_regs[6] = 32'h55555555;
    check("late_aw_b", 256'({bus.b_valid, bus.b_resp}), 256'(3'b100));
    check("late_aw_reg_q", reg_q, pack_exp());
    @(posedge aclk); #1;
    bus.b_ready = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
